// File: rtl/router_pkg.sv
// Shared definitions for the 1xN router control path: state encoding, default
// sizing and the decodes that the synchroniser and checkers reuse.
package router_pkg;

    localparam int NUM_CH_DEF = 3;
    localparam int ADDR_W_DEF = 2;

    typedef logic [3:0] state_t;

    localparam state_t DECODE_ADDRESS     = 4'd0;
    localparam state_t LOAD_FIRST_DATA    = 4'd1;
    localparam state_t LOAD_DATA          = 4'd2;
    localparam state_t FIFO_FULL_STATE    = 4'd3;
    localparam state_t LOAD_AFTER_FULL    = 4'd4;
    localparam state_t LOAD_PARITY        = 4'd5;
    localparam state_t CHECK_PARITY_ERROR = 4'd6;
    localparam state_t WAIT_TILL_EMPTY    = 4'd7;
    localparam state_t DROP_PACKET        = 4'd8;

    function automatic logic write_enb_decode(input state_t s);
        return (s == LOAD_DATA) || (s == LOAD_PARITY) || (s == LOAD_AFTER_FULL);
    endfunction

    // The input bus is free to stream in LOAD_DATA and while a packet is drained.
    function automatic logic busy_decode(input state_t s);
        return !((s == DECODE_ADDRESS) || (s == LOAD_DATA) || (s == DROP_PACKET));
    endfunction

endpackage

// File: rtl/router_wait_timer.sv
// Cycle counter bounding how long the router waits for a destination FIFO to drain.
module router_wait_timer
#(
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 1023
)
(
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = (count == CNT_W'(WAIT_MAX - 1));

endmodule

// File: rtl/router_fsm_n.sv
// Control FSM for a 1xNUM_CH packet router: header decode, payload/parity load,
// full stalls, bounded wait for an empty FIFO and dropping of unroutable packets.
module router_fsm_n
    import router_pkg::*;
#(
    parameter int NUM_CH   = NUM_CH_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int WAIT_MAX = 1023,
    parameter int CNT_W    = 16
)
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic              low_pkt_valid,
    input  logic              parity_done,
    input  logic [ADDR_W-1:0] addr,
    input  logic              fifo_full,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic [NUM_CH-1:0] soft_reset,
    output logic [ADDR_W-1:0] dest_addr,
    output logic              busy,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg,
    output logic              drop_pkt,
    output logic              wait_timeout
);

    // Per-channel flags are widened to the full address space so any address,
    // including an unroutable one, indexes a defined (zero) bit.
    localparam int ADDR_SPACE = 1 << ADDR_W;

    state_t                  state;
    state_t                  next_state;
    logic [ADDR_SPACE-1:0]   empty_ext;
    logic [ADDR_SPACE-1:0]   soft_ext;
    logic                    addr_in_range;
    logic                    soft_hit;
    logic                    wait_expire;
    logic                    in_wait;

    assign empty_ext     = ADDR_SPACE'(fifo_empty);
    assign soft_ext      = ADDR_SPACE'(soft_reset);
    assign addr_in_range = ({1'b0, addr} < (ADDR_W + 1)'(NUM_CH));
    assign soft_hit      = soft_ext[dest_addr] && (state != DECODE_ADDRESS);
    assign in_wait       = (state == WAIT_TILL_EMPTY);

    router_wait_timer #(
        .CNT_W    (CNT_W),
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clock  (clock),
        .resetn (resetn),
        .clear  (!in_wait),
        .enable (in_wait),
        .expire (wait_expire)
    );

    always_comb begin
        next_state = state;
        case (state)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    if (!addr_in_range) begin
                        next_state = DROP_PACKET;
                    end else if (empty_ext[addr]) begin
                        next_state = LOAD_FIRST_DATA;
                    end else begin
                        next_state = WAIT_TILL_EMPTY;
                    end
                end
            end
            LOAD_FIRST_DATA: next_state = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full) begin
                    next_state = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    next_state = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) begin
                    next_state = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    next_state = DECODE_ADDRESS;
                end else if (low_pkt_valid) begin
                    next_state = LOAD_PARITY;
                end else begin
                    next_state = LOAD_DATA;
                end
            end
            LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                if (empty_ext[dest_addr]) begin
                    next_state = LOAD_FIRST_DATA;
                end else if (wait_expire) begin
                    next_state = DROP_PACKET;
                end
            end
            DROP_PACKET: begin
                if (!pkt_valid) begin
                    next_state = DECODE_ADDRESS;
                end
            end
            default: next_state = DECODE_ADDRESS;
        endcase
        if (soft_hit) begin
            next_state = DECODE_ADDRESS;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= DECODE_ADDRESS;
            dest_addr <= '0;
        end else begin
            state <= next_state;
            if ((state == DECODE_ADDRESS) && pkt_valid) begin
                dest_addr <= addr;
            end
        end
    end

    // The timeout pulse only fires when the wait genuinely ends in a drop.
    assign wait_timeout  = in_wait && wait_expire && !empty_ext[dest_addr] && !soft_hit;

    assign detect_add    = (state == DECODE_ADDRESS);
    assign lfd_state     = (state == LOAD_FIRST_DATA);
    assign ld_state      = (state == LOAD_DATA);
    assign laf_state     = (state == LOAD_AFTER_FULL);
    assign full_state    = (state == FIFO_FULL_STATE);
    assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
    assign drop_pkt      = (state == DROP_PACKET);
    assign write_enb_reg = write_enb_decode(state);
    assign busy          = busy_decode(state);

endmodule

// File: tb/tb_router_fsm_n.sv
// Directed bench for router_fsm_n with a cycle-level packet-flow model and
// literal spot checks.
module tb_router_fsm_n;

    localparam int NUM_CH   = 3;
    localparam int ADDR_W   = 2;
    localparam int WAIT_MAX = 8;
    localparam int CNT_W    = 16;

    logic              clock = 1'b0;
    logic              resetn;
    logic              pkt_valid;
    logic              low_pkt_valid;
    logic              parity_done;
    logic [ADDR_W-1:0] addr;
    logic              fifo_full;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] soft_reset;
    logic [ADDR_W-1:0] dest_addr;
    logic              busy, detect_add, lfd_state, ld_state, laf_state, full_state;
    logic              write_enb_reg, rst_int_reg, drop_pkt, wait_timeout;

    always #5 clock = ~clock;

    router_fsm_n #(
        .NUM_CH   (NUM_CH),
        .ADDR_W   (ADDR_W),
        .WAIT_MAX (WAIT_MAX),
        .CNT_W    (CNT_W)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .low_pkt_valid (low_pkt_valid),
        .parity_done   (parity_done),
        .addr          (addr),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .soft_reset    (soft_reset),
        .dest_addr     (dest_addr),
        .busy          (busy),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .write_enb_reg (write_enb_reg),
        .rst_int_reg   (rst_int_reg),
        .drop_pkt      (drop_pkt),
        .wait_timeout  (wait_timeout)
    );

    typedef enum int {M_DEC, M_LFD, M_LD, M_FULL, M_LAF, M_LP, M_CPE, M_WAIT, M_DROP} mstate_t;

    mstate_t    m_st = M_DEC;
    mstate_t    m_nx;
    int         m_dest = 0;
    int         m_waited = 0;
    bit         m_ready = 1'b0;
    int         n_compared = 0;
    int         n_mismatched = 0;
    int         pulses = 0;
    logic [9:0] act_vec;
    logic [9:0] exp_vec;

    function automatic bit chan(input logic [NUM_CH-1:0] v, input int idx);
        if (idx < NUM_CH) return (v[idx] === 1'b1);
        return 1'b0;
    endfunction

    // Model of the packet flow, advanced on each rising edge from the sampled inputs.
    always @(posedge clock) begin
        if (resetn === 1'b0) begin
            m_st     = M_DEC;
            m_dest   = 0;
            m_waited = 0;
            m_ready  = 1'b1;
        end else if (m_ready) begin
            m_nx = m_st;
            if (m_st != M_DEC && chan(soft_reset, m_dest)) begin
                m_nx = M_DEC;
            end else begin
                case (m_st)
                    M_DEC: if (pkt_valid) begin
                        m_dest = int'(addr);
                        if (m_dest >= NUM_CH)              m_nx = M_DROP;
                        else if (chan(fifo_empty, m_dest)) m_nx = M_LFD;
                        else                               m_nx = M_WAIT;
                    end
                    M_LFD:  m_nx = M_LD;
                    M_LD:   if (fifo_full) m_nx = M_FULL; else if (!pkt_valid) m_nx = M_LP;
                    M_FULL: if (!fifo_full) m_nx = M_LAF;
                    M_LAF:  m_nx = parity_done ? M_DEC : (low_pkt_valid ? M_LP : M_LD);
                    M_LP:   m_nx = M_CPE;
                    M_CPE:  m_nx = fifo_full ? M_FULL : M_DEC;
                    M_WAIT: if (chan(fifo_empty, m_dest)) m_nx = M_LFD;
                            else if (m_waited + 1 >= WAIT_MAX) m_nx = M_DROP;
                    M_DROP: if (!pkt_valid) m_nx = M_DEC;
                    default: m_nx = M_DEC;
                endcase
            end
            m_waited = (m_st == M_WAIT && m_nx == M_WAIT) ? m_waited + 1 : 0;
            m_st = m_nx;
        end
    end

    function automatic logic [9:0] model_outputs();
        bit wt;
        wt = (m_st == M_WAIT) && !chan(fifo_empty, m_dest) && !chan(soft_reset, m_dest)
             && (m_waited + 1 == WAIT_MAX);
        return {!(m_st inside {M_DEC, M_LD, M_DROP}), m_st == M_DEC, m_st == M_LFD,
                m_st == M_LD, m_st == M_LAF, m_st == M_FULL,
                m_st inside {M_LD, M_LP, M_LAF}, m_st == M_CPE, m_st == M_DROP, wt};
    endfunction

    always @(negedge clock) begin
        if (m_ready) begin
            act_vec = {busy, detect_add, lfd_state, ld_state, laf_state, full_state,
                       write_enb_reg, rst_int_reg, drop_pkt, wait_timeout};
            exp_vec = model_outputs();
            n_compared++;
            if (act_vec !== exp_vec) begin
                n_mismatched++;
                $display("[TB] FAIL outputs t=%0t got %b expected %b (busy,det,lfd,ld,laf,full,wen,rst,drop,wt)",
                         $time, act_vec, exp_vec);
            end
            n_compared++;
            if (dest_addr !== ADDR_W'(m_dest)) begin
                n_mismatched++;
                $display("[TB] FAIL dest_addr t=%0t got %0d expected %0d", $time, dest_addr, m_dest);
            end
            if (wait_timeout === 1'b1) pulses++;
        end
    end

    task automatic applyStimulus(input logic pv, input logic lpv, input logic pd,
                                 input logic [ADDR_W-1:0] ad, input logic ff,
                                 input logic [NUM_CH-1:0] fe, input logic [NUM_CH-1:0] sr,
                                 input logic rn);
        pkt_valid     = pv;
        low_pkt_valid = lpv;
        parity_done   = pd;
        addr          = ad;
        fifo_full     = ff;
        fifo_empty    = fe;
        soft_reset    = sr;
        resetn        = rn;
        @(posedge clock);
        #2;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s got %0d expected %0d", name, actual, expected);
        end
    endtask

    initial begin
        // Reset
        applyStimulus(0, 0, 0, 0, 0, 3'b111, 3'b000, 0);
        checkOutput("reset_detect_add", detect_add, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_dest", dest_addr, 0);

        // Normal packet to channel 2
        applyStimulus(1, 0, 0, 2, 0, 3'b100, 3'b000, 1);
        checkOutput("t1_lfd", lfd_state, 1);
        checkOutput("t1_lfd_busy", busy, 1);
        applyStimulus(1, 0, 0, 2, 0, 3'b100, 3'b000, 1);
        checkOutput("t1_ld_wen", write_enb_reg, 1);
        checkOutput("t1_ld_busy", busy, 0);
        applyStimulus(1, 0, 0, 2, 0, 3'b100, 3'b000, 1);
        applyStimulus(0, 0, 0, 2, 0, 3'b100, 3'b000, 1);
        checkOutput("t1_lp_wen", write_enb_reg, 1);
        applyStimulus(0, 0, 0, 2, 0, 3'b100, 3'b000, 1);
        checkOutput("t1_cpe_rst", rst_int_reg, 1);
        applyStimulus(0, 0, 0, 2, 0, 3'b100, 3'b000, 1);
        checkOutput("t1_back_decode", detect_add, 1);
        checkOutput("t1_dest", dest_addr, 2);

        // Out-of-range address dropped
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 3, 0, 3'b111, 3'b000, 1);
        checkOutput("t2_drop", drop_pkt, 1);
        checkOutput("t2_busy", busy, 0);
        applyStimulus(0, 0, 0, 3, 0, 3'b111, 3'b000, 1);
        checkOutput("t2_back_decode", detect_add, 1);

        // Wait timeout on channel 1
        applyStimulus(1, 0, 0, 1, 0, 3'b000, 3'b000, 1);
        for (int i = 0; i < 7; i++) applyStimulus(1, 0, 0, 1, 0, 3'b000, 3'b000, 1);
        checkOutput("t3_no_pulse_yet", pulses, 0);
        applyStimulus(1, 0, 0, 1, 0, 3'b000, 3'b000, 1);
        checkOutput("t3_drop_after_timeout", drop_pkt, 1);
        checkOutput("t3_one_pulse", pulses, 1);
        applyStimulus(0, 0, 0, 1, 0, 3'b000, 3'b000, 1);

        // Empty wins on the last wait cycle
        applyStimulus(1, 0, 0, 1, 0, 3'b000, 3'b000, 1);
        for (int i = 0; i < 7; i++) applyStimulus(1, 0, 0, 1, 0, 3'b000, 3'b000, 1);
        applyStimulus(1, 0, 0, 1, 0, 3'b010, 3'b000, 1);
        checkOutput("t3b_lfd", lfd_state, 1);
        checkOutput("t3b_no_pulse", pulses, 1);
        applyStimulus(1, 0, 0, 1, 0, 3'b010, 3'b000, 1);
        applyStimulus(0, 0, 0, 1, 0, 3'b010, 3'b000, 1);
        applyStimulus(0, 0, 0, 1, 0, 3'b010, 3'b000, 1);
        applyStimulus(0, 0, 0, 1, 0, 3'b010, 3'b000, 1);

        // FIFO full stall, release with low_pkt_valid
        applyStimulus(1, 0, 0, 0, 0, 3'b111, 3'b000, 1);
        applyStimulus(1, 0, 0, 0, 0, 3'b111, 3'b000, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 1, 3'b111, 3'b000, 1);
        checkOutput("t4_full", full_state, 1);
        checkOutput("t4_full_busy", busy, 1);
        applyStimulus(0, 1, 0, 0, 0, 3'b111, 3'b000, 1);
        checkOutput("t4_laf", laf_state, 1);
        applyStimulus(0, 1, 0, 0, 0, 3'b111, 3'b000, 1);
        applyStimulus(0, 0, 0, 0, 0, 3'b111, 3'b000, 1);
        applyStimulus(0, 0, 0, 0, 1, 3'b111, 3'b000, 1);
        checkOutput("t4_cpe_to_full", full_state, 1);
        applyStimulus(0, 0, 0, 0, 0, 3'b111, 3'b000, 1);
        applyStimulus(0, 0, 1, 0, 0, 3'b111, 3'b000, 1);
        checkOutput("t4_parity_done_decode", detect_add, 1);

        // Soft reset: other channel ignored, own channel aborts
        applyStimulus(1, 0, 0, 2, 0, 3'b111, 3'b000, 1);
        applyStimulus(1, 0, 0, 2, 0, 3'b111, 3'b000, 1);
        applyStimulus(1, 0, 0, 2, 0, 3'b111, 3'b001, 1);
        checkOutput("t5_ignored", ld_state, 1);
        applyStimulus(1, 0, 0, 2, 0, 3'b111, 3'b100, 1);
        checkOutput("t5_soft_decode", detect_add, 1);
        applyStimulus(0, 0, 0, 2, 0, 3'b111, 3'b000, 1);

        // Hard reset wins over soft reset mid-stall
        applyStimulus(1, 0, 0, 1, 0, 3'b111, 3'b000, 1);
        applyStimulus(1, 0, 0, 1, 0, 3'b111, 3'b000, 1);
        applyStimulus(1, 0, 0, 1, 1, 3'b111, 3'b000, 1);
        applyStimulus(1, 0, 0, 1, 1, 3'b111, 3'b010, 0);
        checkOutput("t6_detect", detect_add, 1);
        checkOutput("t6_dest", dest_addr, 0);
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_full", full_state, 0);
        applyStimulus(0, 0, 0, 0, 0, 3'b111, 3'b000, 1);
        applyStimulus(0, 0, 0, 0, 0, 3'b111, 3'b000, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
